// File: rtl/spi_adc_pkg.sv
// Shared types and constants for the ADC128S SPI slave front-end.
package spi_adc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;

  // Bit count value that marks a complete frame; the counter saturates here.
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for an asynchronous pin with rise/fall event outputs.
// The second flop is the synchronized level; the third flop remembers the
// previous level so single-cycle edge pulses can be derived.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Shift the pin value through the chain, oldest sample in the top bit.
  always_comb begin
    sync_d = {sync_q[1:0], d_in};
  end

  // Chain register; resets to the pin's idle level so no false edge appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {3{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_adc128s_slave.sv
// SPI mode-0 slave front-end of the ADC128S behavioural model.
// Receives a 16-bit command word and returns A2D_data in the same frame.
// Optional macro SPI_MISO_TRISTATE_EN: MISO floats (1'bz) while the slave
// is deselected; without it MISO is driven low while deselected.
module spi_adc128s_slave
  import spi_adc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] A2D_data,
  output logic [15:0] cmd,
  output logic        rdy
);

  // Synchronized pin levels and edge events.
  logic ss_sync, ss_rise, ss_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic mosi_sync;

  logic [1:0] mosi_q, mosi_d;

  state_t             state_q, state_d;
  logic [15:0]        tx_shft_q, tx_shft_d;
  logic [15:0]        rx_shft_q, rx_shft_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [15:0]        cmd_q, cmd_d;
  logic               rdy_q, rdy_d;

  // Values after this cycle's SCLK rise, used by the end-of-frame check so a
  // coincident rise is counted before the frame is judged.
  logic [15:0]        rx_after;
  logic [CNT_W-1:0]   cnt_after;

  logic miso_en, miso_bit;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_in   (SS_n),
    .sync_o (ss_sync),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_in   (SCLK),
    .sync_o (sclk_lvl_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // MOSI needs only two stages; it is sampled on the synchronized SCLK rise.
  always_comb begin
    mosi_d = {mosi_q[0], MOSI};
  end

  assign mosi_sync = mosi_q[1];

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mosi_q    <= 2'b00;
      tx_shft_q <= 16'h0000;
      rx_shft_q <= 16'h0000;
      bit_cnt_q <= '0;
      cmd_q     <= 16'h0000;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mosi_q    <= mosi_d;
      tx_shft_q <= tx_shft_d;
      rx_shft_q <= rx_shft_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      rdy_q     <= rdy_d;
    end
  end

  // Next-state logic: a select fall starts (or restarts) a frame, a select
  // rise ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = SHIFT;
      SHIFT: begin
        if (ss_fall)      state_d = SHIFT;
        else if (ss_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on frame start, shift on SCLK edges, publish on frame end.
  always_comb begin
    tx_shft_d = tx_shft_q;
    rx_shft_d = rx_shft_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    rdy_d     = rdy_q;
    rx_after  = rx_shft_q;
    cnt_after = bit_cnt_q;

    if (ss_fall) begin
      // Frame start (or restart of a frame that never closed).
      tx_shft_d = A2D_data;
      bit_cnt_d = '0;
      rdy_d     = 1'b0;
    end else if (state_q == SHIFT) begin
      if (sclk_rise) begin
        rx_after = {rx_shft_q[14:0], mosi_sync};
        if (bit_cnt_q != FRAME_CNT) begin
          cnt_after = bit_cnt_q + 1'b1;
        end
      end
      // The first fall of a frame follows the first rise, whose bit was
      // already presented on MISO since the load; shift only after that.
      if (sclk_fall && (bit_cnt_q != '0)) begin
        tx_shft_d = {tx_shft_q[14:0], 1'b0};
      end
      rx_shft_d = rx_after;
      bit_cnt_d = cnt_after;
      if (ss_rise && (cnt_after == FRAME_CNT)) begin
        cmd_d = rx_after;
        rdy_d = 1'b1;
      end
    end
  end

  // Output logic: MISO follows the transmit MSB while selected.
  always_comb begin
    miso_en  = ~ss_sync;
    miso_bit = tx_shft_q[15];
  end

`ifdef SPI_MISO_TRISTATE_EN
  assign MISO = miso_en ? miso_bit : 1'bz;
`else
  assign MISO = miso_en ? miso_bit : 1'b0;
`endif

  assign cmd = cmd_q;
  assign rdy = rdy_q;

endmodule

// File: tb/tb_spi_adc128s_slave.sv
// Directed bench for spi_adc128s_slave: a bit-banged SPI master, a frame-level
// model of cmd/rdy/MISO, and a per-cycle compare against that model.
module tb_spi_adc128s_slave;
  import spi_adc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic [15:0] A2D_data = 16'h0000;
  wire         MISO;
  logic [15:0] cmd;
  logic        rdy;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ss_edge_cyc = 0;
  int hp = 4;
  int rdy_rises = 0;
  int r0;

  // Frame-level model state.
  logic [15:0] exp_cmd = 16'h0000;
  logic        exp_rdy = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] last_miso;

  spi_adc128s_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .A2D_data (A2D_data),
    .cmd      (cmd),
    .rdy      (rdy)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge rdy) rdy_rises++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of cmd/rdy (and idle MISO) once a select edge settled.
  always @(posedge clk) begin
    #1;
    if (rst_n && ((cyc - ss_edge_cyc) > 4)) begin
      check("cmd_model", {16'h0, cmd}, {16'h0, exp_cmd});
      check("rdy_model", {31'h0, rdy}, {31'h0, exp_rdy});
      if (SS_n) begin
`ifdef SPI_MISO_TRISTATE_EN
        check("miso_idle", {31'h0, MISO}, {31'h0, 1'bz});
`else
        check("miso_idle", {31'h0, MISO}, 32'h0);
`endif
      end
    end
  end

  // One SPI frame of nbits bits (MSB first from word[nbits-1]). A2D_data is
  // switched to a2d_late during the frame to probe the load window.
  task automatic spi_frame(input logic [31:0] word, input int nbits,
                           input logic [15:0] a2d, input logic [15:0] a2d_late);
    logic [15:0] got;
    logic [15:0] exp_word;
    int nb;
    got = 16'h0;
    A2D_data = a2d;
    @(negedge clk);
    SS_n = 1'b0;
    ss_edge_cyc = cyc;
    exp_rdy = 1'b0;
    exp_q.push_back(a2d);
    for (int i = 0; i < nbits; i++) begin
      MOSI = word[nbits-1-i];
      repeat (hp) @(negedge clk);
      if (i < 16) got = {got[14:0], MISO};
      else check("miso_extra_bit", {31'h0, MISO}, 32'h0);
      SCLK = 1'b1;
      if (i == 4) A2D_data = a2d_late;
      repeat (hp) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (hp) @(negedge clk);
    SS_n = 1'b1;
    ss_edge_cyc = cyc;
    if (nbits >= 16) begin
      exp_cmd = word[15:0];
      exp_rdy = 1'b1;
    end
    nb = (nbits < 16) ? nbits : 16;
    exp_word = exp_q.pop_front();
    check("miso_word", {16'h0, got}, {16'h0, exp_word >> (16 - nb)});
    last_miso = got;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset at start.
    repeat (3) @(negedge clk);
    check("reset_cmd", {16'h0, cmd}, 32'h0);
    check("reset_rdy", {31'h0, rdy}, 32'h0);
    check("reset_state", {31'h0, dut.state_q}, {31'h0, IDLE});
    rst_n = 1'b1;
    ss_edge_cyc = cyc;
    repeat (6) @(negedge clk);

    // Single frame.
    r0 = rdy_rises;
    spi_frame(32'h2800, 16, 16'h0C00, 16'h0C00);
    check("single_miso", {16'h0, last_miso}, 32'h0C00);
    check("single_cmd", {16'h0, cmd}, 32'h2800);
    check("single_rdy_rises", rdy_rises, r0 + 1);

    // Back-to-back frames.
    r0 = rdy_rises;
    spi_frame(32'h0000, 16, 16'h0ABC, 16'h0ABC);
    check("b2b1_miso", {16'h0, last_miso}, 32'h0ABC);
    check("b2b1_cmd", {16'h0, cmd}, 32'h0000);
    spi_frame(32'h2000, 16, 16'h0BF0, 16'h0BF0);
    check("b2b2_miso", {16'h0, last_miso}, 32'h0BF0);
    check("b2b2_cmd", {16'h0, cmd}, 32'h2000);
    check("b2b_rdy_rises", rdy_rises, r0 + 2);

    // Short frame: discarded.
    r0 = rdy_rises;
    spi_frame(32'h0FFF, 12, 16'h0123, 16'h0123);
    check("short_cmd", {16'h0, cmd}, 32'h2000);
    check("short_rdy", {31'h0, rdy}, 32'h0);
    check("short_rdy_rises", rdy_rises, r0);

    // Data sampling window: late A2D change must not leak into the frame.
    spi_frame(32'h1234, 16, 16'h0A5A, 16'h0FFF);
    check("window_miso", {16'h0, last_miso}, 32'h0A5A);
    check("window_cmd", {16'h0, cmd}, 32'h1234);

    // Overlong frame: last 16 bits win.
    spi_frame(32'h0002ABCD, 18, 16'h0321, 16'h0321);
    check("long_cmd", {16'h0, cmd}, 32'hABCD);

    // Minimum timing, all-ones and alternating patterns.
    hp = 4;
    spi_frame(32'hFFFF, 16, 16'hFFFF, 16'hFFFF);
    check("min_ffff_miso", {16'h0, last_miso}, 32'hFFFF);
    check("min_ffff_cmd", {16'h0, cmd}, 32'hFFFF);
    spi_frame(32'h5555, 16, 16'h5555, 16'h5555);
    check("min_5555_miso", {16'h0, last_miso}, 32'h5555);
    check("min_5555_cmd", {16'h0, cmd}, 32'h5555);

    // Slower master.
    hp = 6;
    spi_frame(32'hA5C3, 16, 16'h0F0F, 16'h0F0F);
    check("slow_miso", {16'h0, last_miso}, 32'h0F0F);
    check("slow_cmd", {16'h0, cmd}, 32'hA5C3);
    hp = 4;

    // Reset in the middle of a frame.
    @(negedge clk);
    SS_n = 1'b0;
    ss_edge_cyc = cyc;
    exp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'b1;
      repeat (hp) @(negedge clk);
      SCLK = 1'b1;
      repeat (hp) @(negedge clk);
      SCLK = 1'b0;
    end
    rst_n = 1'b0;
    exp_cmd = 16'h0000;
    #1;
    check("midreset_cmd", {16'h0, cmd}, 32'h0);
    check("midreset_rdy", {31'h0, rdy}, 32'h0);
    check("midreset_state", {31'h0, dut.state_q}, {31'h0, IDLE});
`ifdef SPI_MISO_TRISTATE_EN
    check("midreset_miso", {31'h0, MISO}, {31'h0, 1'bz});
`else
    check("midreset_miso", {31'h0, MISO}, 32'h0);
`endif
    @(negedge clk);
    SS_n = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ss_edge_cyc = cyc;
    repeat (6) @(negedge clk);

    // Normal operation after reset.
    r0 = rdy_rises;
    spi_frame(32'h2800, 16, 16'h0C00, 16'h0C00);
    check("post_reset_miso", {16'h0, last_miso}, 32'h0C00);
    check("post_reset_cmd", {16'h0, cmd}, 32'h2800);
    check("post_reset_rdy_rises", rdy_rises, r0 + 1);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
